// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bundle: two valid/ready write sources, issue tap, and the
// registered register-file write port plus pending-producer scoreboard.
interface wb_port_arbiter_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            wb_hold;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy_mask;

    modport master (
        output wb_hold, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd,
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );

    modport slave (
        input  wb_hold, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the GPR write port between ALU and load returns, with busy scoreboard.
// Latency: accept -> rf_we 1 cycle; accept -> busy clear 2 edges.
// Backpressure: readies are combinational from valids/wb_hold/reset/last; wb_hold or reset deasserts both.
module wb_port_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    src_e            r_last;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [NREG-1:0] r_busy;

    logic            w_open;
    logic            w_alu_rdy;
    logic            w_mem_rdy;
    logic [NREG-1:0] w_busy_nxt;

    assign w_open = !reset && !bus.wb_hold;

    // The source that did not win last time gets the tie.
    always_comb begin
        w_alu_rdy = w_open && bus.alu_valid && (!bus.mem_valid || r_last == SRC_MEM);
        w_mem_rdy = w_open && bus.mem_valid && (!bus.alu_valid || r_last == SRC_ALU);
    end

    // Clear on the committing write, then set so a younger producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= SRC_ALU;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_alu_rdy) begin
                r_last  <= SRC_ALU;
                r_we    <= (bus.alu_rd != '0);
                r_waddr <= bus.alu_rd;
                r_wdata <= bus.alu_data;
            end else if (w_mem_rdy) begin
                r_last  <= SRC_MEM;
                r_we    <= (bus.mem_rd != '0);
                r_waddr <= bus.mem_rd;
                r_wdata <= bus.mem_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.alu_ready = w_alu_rdy;
    assign bus.mem_ready = w_mem_rdy;
    assign bus.rf_we     = r_we;
    assign bus.rf_waddr  = r_waddr;
    assign bus.rf_wdata  = r_wdata;
    assign bus.busy_mask = r_busy;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed expectations checked with immediate assertions.
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    wb_port_arbiter_if #(.XLEN(64), .NREG(32), .AW(5)) bus ();

    wb_port_arbiter #(.XLEN(64), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.mem_valid   = 1'b0;
        bus.issue_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.wb_hold  = 1'b0;
        bus.alu_rd   = '0;
        bus.alu_data = '0;
        bus.mem_rd   = '0;
        bus.mem_data = '0;
        bus.issue_rd = '0;
        idle();
        step();
        step();
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", bus.rf_wdata, 64'd0);
        chk("rst_busy", 64'(bus.busy_mask), 64'd0);
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        #1;
        chk("rst_alu_rdy", 64'(bus.alu_ready), 64'd0);
        chk("rst_mem_rdy", 64'(bus.mem_ready), 64'd0);
        idle();
        step();
        reset = 1'b0;

        // Single ALU write rd=5
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h11;
        #1;
        chk("single_alu_rdy", 64'(bus.alu_ready), 64'd1);
        chk("single_mem_rdy", 64'(bus.mem_ready), 64'd0);
        step();
        idle();
        chk("single_we", 64'(bus.rf_we), 64'd1);
        chk("single_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("single_wdata", bus.rf_wdata, 64'h11);
        step();
        chk("single_we_off", 64'(bus.rf_we), 64'd0);
        chk("single_waddr_hold", 64'(bus.rf_waddr), 64'd5);
        chk("single_wdata_hold", bus.rf_wdata, 64'h11);

        // Both valid: mem, alu, mem, alu
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hA3;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'hB4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_mem_rdy", 64'(bus.mem_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_alu_rdy", 64'(bus.alu_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            step();
            chk("rr_we", 64'(bus.rf_we), 64'd1);
            chk("rr_waddr", 64'(bus.rf_waddr), (i % 2 == 0) ? 64'd4 : 64'd3);
            chk("rr_wdata", bus.rf_wdata, (i % 2 == 0) ? 64'hB4 : 64'hA3);
        end
        idle();
        step();
        chk("rr_we_off", 64'(bus.rf_we), 64'd0);

        // Scoreboard set by issue, cleared by write
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        idle();
        chk("sb_set7", 64'(bus.busy_mask), 64'h80);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
        #1;
        chk("sb_alu_rdy", 64'(bus.alu_ready), 64'd1);
        step();
        idle();
        chk("sb_we7", 64'(bus.rf_we), 64'd1);
        chk("sb_waddr7", 64'(bus.rf_waddr), 64'd7);
        chk("sb_still_busy", 64'(bus.busy_mask), 64'h80);
        step();
        chk("sb_clear7", 64'(bus.busy_mask), 64'd0);

        // rd=0 write: accepted, flips priority, no write
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 64'hFF;
        #1;
        chk("x0_mem_rdy", 64'(bus.mem_ready), 64'd1);
        step();
        idle();
        chk("x0_we", 64'(bus.rf_we), 64'd0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4;
        #1;
        chk("x0_last_alu_rdy", 64'(bus.alu_ready), 64'd1);
        chk("x0_last_mem_rdy", 64'(bus.mem_ready), 64'd0);
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        step();
        idle();
        chk("x0_issue_busy", 64'(bus.busy_mask), 64'd0);

        // Set and clear of rd=9 on the same edge: set wins
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h99;
        step();
        idle();
        chk("same_we9", 64'(bus.rf_we), 64'd1);
        chk("same_waddr9", 64'(bus.rf_waddr), 64'd9);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        idle();
        chk("same_busy9", 64'(bus.busy_mask), 64'h200);

        // wb_hold: a registered write still lands, no new grants
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 64'hAA;
        #1;
        chk("hold_pre_rdy", 64'(bus.alu_ready), 64'd1);
        step();
        bus.wb_hold = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'hB4;
        #1;
        chk("hold_we_lands", 64'(bus.rf_we), 64'd1);
        chk("hold_waddr", 64'(bus.rf_waddr), 64'd10);
        chk("hold_alu_rdy", 64'(bus.alu_ready), 64'd0);
        chk("hold_mem_rdy", 64'(bus.mem_ready), 64'd0);
        step();
        chk("hold_we1", 64'(bus.rf_we), 64'd0);
        chk("hold_alu_rdy1", 64'(bus.alu_ready), 64'd0);
        chk("hold_mem_rdy1", 64'(bus.mem_ready), 64'd0);
        step();
        chk("hold_we2", 64'(bus.rf_we), 64'd0);
        bus.wb_hold = 1'b0;

        // Reset with a write in flight
        #1;
        chk("inflight_mem_rdy", 64'(bus.mem_ready), 64'd1);
        step();
        chk("inflight_we", 64'(bus.rf_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("inflight_rst_rdy", 64'(bus.mem_ready), 64'd0);
        step();
        chk("inflight_rst_we", 64'(bus.rf_we), 64'd0);
        chk("inflight_rst_busy", 64'(bus.busy_mask), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_mem_first", 64'(bus.mem_ready), 64'd1);
        chk("post_rst_alu_wait", 64'(bus.alu_ready), 64'd0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the ALU writeback stream and the memory load-return stream. Each source uses a valid/ready handshake; the block grants one source per cycle round-robin, registers the winning write onto the register-file write port, and keeps a per-register pending (busy) scoreboard so issue logic can detect outstanding producers. It sits between the MEM/WB stage and the GPR file and replaces direct writes from the writeback stage.

## Interface
- XLEN, 64, data width of a register write
- NREG, 32, number of architectural GPRs (x0 hardwired zero)
- AW, 5, register index width (log2 NREG)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wb_hold  in  1  freeze: no grants this cycle
- alu_valid  in  1  ALU result offered
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- mem_valid  in  1  load data offered
- mem_rd  in  AW  load destination register
- mem_data  in  XLEN  loaded data
- mem_ready  out  1  load data accepted this cycle (combinational)
- issue_valid  in  1  instruction with a register destination issued
- issue_rd  in  AW  destination of issued instruction
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write index (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- busy_mask  out  NREG  bit i = register i has an outstanding producer (registered)

## Operation
- Transfer on a source = valid & ready in the same cycle. Sources must hold valid/rd/data stable until accepted.
- Grant:
  - reset or wb_hold high: both readies 0.
  - One source valid: that source gets ready.
  - Both valid: round-robin. Priority pointer `last` records the last granted source; the other source wins. After reset, mem has priority.
  - `last` updates only on an actual transfer.
  - Readies depend only on the valids, wb_hold, reset and `last`; never on rd or data.
- Write stage: on a transfer in cycle N, rf_we=1, rf_waddr=rd, rf_wdata=data during cycle N+1.
  - A transfer with rd=0 is accepted normally and advances `last`, but rf_we stays 0 in N+1.
  - With no transfer in N, rf_we=0 in N+1; rf_waddr and rf_wdata hold their previous values.
- Scoreboard:
  - issue_valid with issue_rd≠0 sets busy_mask[issue_rd] at the end of the cycle.
  - A cycle with rf_we=1 clears busy_mask[rf_waddr] at the end of that cycle, the same edge the register file commits.
  - Same register set and cleared on the same edge: set wins, because the new producer is younger.
  - busy_mask[0] is always 0.
  - The scoreboard is one bit per register. A second issue to a busy register leaves it busy, and the first completing write clears it. Issue logic must not issue a WAW to a busy register.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, `last`=ALU (so mem wins first). alu_ready and mem_ready are 0 while reset is high.
- Reset mid-operation: an accepted transfer whose write has not yet appeared is dropped, and rf_we=0 in the cycle after reset. Pending bits clear.
- Acceptance to rf_we: 1 cycle. Acceptance to busy clear: 2 edges (the acceptance edge, then the write edge).
- Throughput: 1 write per cycle. With both sources continuously valid, grants alternate, so no source waits more than 1 cycle.
- wb_hold does not suppress a write already registered. That write still appears in the next cycle.

## Test plan
- Reset, then only alu_valid with rd=5, data=0x11 → alu_ready=1 in the same cycle. Next cycle: rf_we=1, waddr=5, wdata=0x11. Cycle after: rf_we=0.
- Both valid for 4 cycles (alu rd=3, mem rd=4) → grants in order mem, alu, mem, alu. rf_waddr sequence is 4,3,4,3 with rf_we=1 on every cycle.
- issue rd=7, then ALU write rd=7 → busy_mask[7]=1 from the cycle after issue. It clears after the cycle in which rf_we=1, waddr=7.
- Write to rd=0 with data 0xFF → ready=1 and `last` flips, but rf_we=0. An issue with rd=0 leaves busy_mask=0.
- In the same cycle, issue rd=9 while rf_we=1, waddr=9 → busy_mask[9]=1 afterwards.
- wb_hold=1 with both valid for 2 cycles → both readies 0 and rf_we=0 from the second cycle. Assert reset with a transfer in flight → rf_we=0 and busy_mask=0 next cycle.
